// File: rtl/booth_pp_accum.sv
// Folds 16 latched radix-4 Booth rows into a signed 64-bit product, ROWS_PER_CYCLE rows per clock.
// Result appears N_ACC cycles after accept; holds in DONE until out_ready, in_ready low while busy.
module booth_pp_accum #(
  parameter int ROWS_PER_CYCLE = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [527:0] pp_bus,
  input  logic [15:0]  e_bus,
  input  logic [31:0]  y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  product,
  output logic         busy,
  output logic         chk_err
);

  localparam int         R      = ROWS_PER_CYCLE;
  localparam logic [4:0] STEP   = 5'(R);
  localparam logic [4:0] LAST_K = 5'(16 - R);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t       state;
  logic [527:0] pp_q;
  logic [15:0]  e_q;
  logic [15:0]  neg_q;
  logic [4:0]   row_cnt;
  logic [63:0]  acc;

  logic [15:0]  y_odd;
  logic [32:0]  row_pp;
  logic [63:0]  part;
  logic [63:0]  sum;
  logic         e_bad;

  always_comb begin
    y_odd = '0;
    for (int i = 0; i < 16; i++) begin
      y_odd[i] = y[2*i+1];
    end
  end

  // Row registers shift down each ACC cycle, so the current rows always sit in slots 0..R-1.
  always_comb begin
    row_pp = '0;
    part   = '0;
    e_bad  = 1'b0;
    for (int j = 0; j < R; j++) begin
      row_pp = pp_q[33*j +: 33];
      part   = part + ({{31{row_pp[32]}}, row_pp} << (2*j)) + (64'(neg_q[j]) << (2*j));
      e_bad  = e_bad | (e_q[j] != ~row_pp[32]);
    end
    sum = acc + (part << {row_cnt, 1'b0});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      chk_err   <= 1'b0;
      product   <= '0;
      acc       <= '0;
      row_cnt   <= '0;
      pp_q      <= '0;
      e_q       <= '0;
      neg_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            pp_q     <= pp_bus;
            e_q      <= e_bus;
            neg_q    <= y_odd;
            acc      <= '0;
            row_cnt  <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= ACC;
          end
        end
        ACC: begin
          acc     <= sum;
          row_cnt <= row_cnt + STEP;
          pp_q    <= pp_q >> (33*R);
          e_q     <= e_q >> R;
          neg_q   <= neg_q >> R;
          chk_err <= chk_err | e_bad;
          if (row_cnt == LAST_K) begin
            product   <= sum;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_pp_accum.sv
// Bench for booth_pp_accum at ROWS_PER_CYCLE 1/2/4/16: directed cases, back-pressure, E check, reset abort, random regression.
module tb_booth_pp_accum;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid_a  [4];
  logic         in_ready_a  [4];
  logic [527:0] pp_a        [4];
  logic [15:0]  e_a         [4];
  logic [31:0]  y_a         [4];
  logic         out_valid_a [4];
  logic         out_ready_a [4];
  logic [63:0]  prod_a      [4];
  logic         busy_a      [4];
  logic         chk_a       [4];

  int checks = 0;
  int errors = 0;

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_dut
      booth_pp_accum #(.ROWS_PER_CYCLE(g == 0 ? 1 : g == 1 ? 2 : g == 2 ? 4 : 16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_a[g]),
        .in_ready  (in_ready_a[g]),
        .pp_bus    (pp_a[g]),
        .e_bus     (e_a[g]),
        .y         (y_a[g]),
        .out_valid (out_valid_a[g]),
        .out_ready (out_ready_a[g]),
        .product   (prod_a[g]),
        .busy      (busy_a[g]),
        .chk_err   (chk_a[g])
      );
    end
  endgenerate

  function automatic int nacc(input int u);
    case (u)
      0:       return 16;
      1:       return 8;
      2:       return 4;
      default: return 1;
    endcase
  endfunction

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] yv);
    logic signed [63:0] a, b;
    a = {{32{x[31]}}, x};
    b = {{32{yv[31]}}, yv};
    return a * b;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Upstream radix-4 Booth generator: negative digits (and -0) sent as one's complement.
  task automatic make_set(input logic [31:0] x, input logic [31:0] yv,
                          output logic [527:0] pp, output logic [15:0] e);
    logic signed [32:0] xs, m;
    logic [32:0] row;
    int d, lo;
    xs = {x[31], x};
    pp = '0;
    e  = '0;
    for (int i = 0; i < 16; i++) begin
      lo = (i == 0) ? 0 : int'(yv[2*i-1]);
      d  = int'(yv[2*i]) + lo - 2*int'(yv[2*i+1]);
      if (d == 2 || d == -2) m = xs <<< 1;
      else if (d == 0)       m = '0;
      else                   m = xs;
      row = yv[2*i+1] ? ~m : m;
      pp[33*i +: 33] = row;
      e[i] = ~row[32];
    end
  endtask

  task automatic drive_set(input int u, input logic [31:0] x, input logic [31:0] yv, input bit corrupt);
    logic [527:0] pp;
    logic [15:0]  e;
    make_set(x, yv, pp, e);
    if (corrupt) e[3] = ~e[3];
    pp_a[u] = pp;
    e_a[u]  = e;
    y_a[u]  = yv;
  endtask

  task automatic wait_out(input int u, output int n);
    n = 0;
    while (!out_valid_a[u] && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Called at a negedge; returns at a negedge after the product has been consumed.
  task automatic run_op(input int u, input logic [31:0] x, input logic [31:0] yv, input bit corrupt,
                        input logic [63:0] exp, input logic exp_chk, input string tag);
    int n;
    drive_set(u, x, yv, corrupt);
    in_valid_a[u] = 1'b1;
    n = 0;
    while (!in_ready_a[u] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check({tag, "_accept_timeout"}, 64'(in_ready_a[u]), 64'd1);
    @(negedge clk);
    in_valid_a[u] = 1'b0;
    wait_out(u, n);
    check({tag, "_lat"}, 64'(n), 64'(nacc(u)));
    check({tag, "_prod"}, prod_a[u], exp);
    check({tag, "_chk"}, 64'(chk_a[u]), 64'(exp_chk));
    out_ready_a[u] = 1'b1;
    @(negedge clk);
    out_ready_a[u] = 1'b0;
    check({tag, "_drop"}, 64'(out_valid_a[u]), 64'd0);
    check({tag, "_rdy"}, 64'(in_ready_a[u]), 64'd1);
  endtask

  task automatic rand_regress(input int u, input int nsets);
    logic [63:0] q[$];
    logic [63:0] exp_cur;
    logic [31:0] x, yv;
    logic [31:0] corner [5];
    int produced, consumed, cyc;
    bit pending;
    corner = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    produced = 0;
    consumed = 0;
    cyc = 0;
    pending = 1'b0;
    exp_cur = '0;
    while (consumed < nsets && cyc < 60*nsets + 1000) begin
      if (!pending) in_valid_a[u] = 1'b0;
      if (!pending && produced < nsets && $urandom_range(3) != 0) begin
        x  = ($urandom_range(7) == 0) ? corner[$urandom_range(4)] : $urandom;
        yv = ($urandom_range(7) == 0) ? corner[$urandom_range(4)] : $urandom;
        drive_set(u, x, yv, 1'b0);
        exp_cur = ref_mul(x, yv);
        in_valid_a[u] = 1'b1;
        pending = 1'b1;
      end
      out_ready_a[u] = ($urandom_range(3) != 0);
      if (pending && in_ready_a[u]) begin
        q.push_back(exp_cur);
        produced++;
        pending = 1'b0;
      end
      if (out_valid_a[u] && out_ready_a[u]) begin
        if (q.size() == 0) check("rand_dup", 64'(out_valid_a[u]), 64'd0);
        else check("rand_prod", prod_a[u], q.pop_front());
        consumed++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid_a[u]  = 1'b0;
    out_ready_a[u] = 1'b0;
    check("rand_consumed", 64'(consumed), 64'(nsets));
    check("rand_balance", 64'(produced), 64'(consumed));
    check("rand_chk", 64'(chk_a[u]), 64'd0);
  endtask

  logic [31:0] dx [4];
  logic [31:0] dy [4];
  logic [63:0] dp [4];

  initial begin
    int n;
    logic [63:0] hold;
    dx = '{32'd3, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    dy = '{32'd5, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000};
    dp = '{64'h0000_0000_0000_000F, 64'h1, 64'h4000_0000_0000_0000, 64'hC000_0000_8000_0000};

    rst = 1'b1;
    for (int u = 0; u < 4; u++) begin
      in_valid_a[u] = 1'b0; out_ready_a[u] = 1'b0;
      pp_a[u] = '0; e_a[u] = '0; y_a[u] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int u = 0; u < 4; u++) begin
      check("rst_in_ready", 64'(in_ready_a[u]), 64'd1);
      check("rst_out_valid", 64'(out_valid_a[u]), 64'd0);
      check("rst_busy", 64'(busy_a[u]), 64'd0);
      check("rst_chk", 64'(chk_a[u]), 64'd0);
      check("rst_product", prod_a[u], 64'd0);
    end

    for (int u = 0; u < 4; u++)
      for (int c = 0; c < 4; c++)
        run_op(u, dx[c], dy[c], 1'b0, dp[c], 1'b0, $sformatf("dir_u%0d_c%0d", u, c));

    // Back-pressure on R=2: a second set waits on in_valid while the first product stalls.
    drive_set(1, 32'd1234567, 32'hFFFF_0F0F, 1'b0);
    in_valid_a[1] = 1'b1;
    @(negedge clk);
    drive_set(1, 32'hDEAD_BEEF, 32'd99, 1'b0);
    wait_out(1, n);
    check("bp_lat", 64'(n), 64'd8);
    hold = ref_mul(32'd1234567, 32'hFFFF_0F0F);
    repeat (5) begin
      @(negedge clk);
      check("bp_prod", prod_a[1], hold);
      check("bp_vld", 64'(out_valid_a[1]), 64'd1);
      check("bp_rdy", 64'(in_ready_a[1]), 64'd0);
    end
    out_ready_a[1] = 1'b1;
    @(negedge clk);
    out_ready_a[1] = 1'b0;
    check("bp_drop", 64'(out_valid_a[1]), 64'd0);
    check("bp_not_taken", 64'(busy_a[1]), 64'd0);
    check("bp_rdy_after", 64'(in_ready_a[1]), 64'd1);
    @(negedge clk);
    in_valid_a[1] = 1'b0;
    wait_out(1, n);
    check("bp2_lat", 64'(n), 64'd8);
    check("bp2_prod", prod_a[1], ref_mul(32'hDEAD_BEEF, 32'd99));
    out_ready_a[1] = 1'b1;
    @(negedge clk);
    out_ready_a[1] = 1'b0;

    // Corrupted E bit on R=4: sticky error, arithmetic unaffected.
    run_op(2, 32'd1000, 32'hFFFF_FFF3, 1'b1, ref_mul(32'd1000, 32'hFFFF_FFF3), 1'b1, "corrupt");
    run_op(2, 32'd17, 32'd19, 1'b0, 64'd323, 1'b1, "sticky");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("chk_cleared", 64'(chk_a[2]), 64'd0);

    // Reset during the third ACC cycle of R=1.
    drive_set(0, 32'h1357_9BDF, 32'h2468_ACE0, 1'b0);
    in_valid_a[0] = 1'b1;
    @(negedge clk);
    in_valid_a[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", 64'(in_ready_a[0]), 64'd1);
    check("abort_out_valid", 64'(out_valid_a[0]), 64'd0);
    check("abort_product", prod_a[0], 64'd0);
    check("abort_busy", 64'(busy_a[0]), 64'd0);
    run_op(0, 32'd7, 32'hFFFF_FFFE, 1'b0, 64'hFFFF_FFFF_FFFF_FFF2, 1'b0, "after_abort");

    for (int u = 0; u < 4; u++) rand_regress(u, 500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
